// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the parametrised APB master:
//   apb_state_e  - bus phase of the master (IDLE / SETUP / ACCESS)
//   READ, WRITE  - encodings of the transfer direction bit
//   rsp_err_e    - cause attached to a completed transfer
//   clog2_min1() - index width helper that never returns 0
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SLAVE   = 2'd1,
    ERR_DECODE  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } rsp_err_e;

  // Width needed to index n items; a single item still gets one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// -----------------------------------------------------------------------------
// apb_slave_mux
// Combinational return-path selector: picks the addressed slave's PREADY,
// PRDATA and PSLVERR out of the per-slave vectors.
// Ports:
//   sel      in   SEL_W          slave index
//   pready   in   N_SLV          per-slave ready
//   prdata   in   N_SLV*DATA_W   per-slave read data, slave i at [i*DATA_W +: DATA_W]
//   pslverr  in   N_SLV          per-slave error
//   ready_c  out  1              selected ready (0 when sel is out of range)
//   rdata_c  out  DATA_W         selected read data (0 when sel is out of range)
//   err_c    out  1              selected error (1 when sel is out of range)
// -----------------------------------------------------------------------------
module apb_slave_mux #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_SLV  = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_SLV-1:0]        pready,
  input  logic [N_SLV*DATA_W-1:0] prdata,
  input  logic [N_SLV-1:0]        pslverr,
  output logic                    ready_c,
  output logic [DATA_W-1:0]       rdata_c,
  output logic                    err_c
);

  // An index with no matching slave reads as "never ready, erroring".
  always_comb begin
    ready_c = 1'b0;
    err_c   = 1'b1;
    rdata_c = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (sel == SEL_W'(i)) begin
        ready_c = pready[i];
        err_c   = pslverr[i];
        rdata_c = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/apb_master_n.sv
// -----------------------------------------------------------------------------
// apb_master_n
// Single-transfer requester to APB bridge with N_SLV one-hot slave selects.
// Supports reads and writes, PSLVERR capture, out-of-range select decode
// errors, an optional ACCESS-phase timeout and back-to-back transfers.
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (o_req_ready combinational)
//   i_req_write/sel/addr/wdata  request payload
//   o_rsp_valid         one-cycle response pulse
//   o_rsp_rdata         read data (0 for writes and errors)
//   o_rsp_err           slave error, decode error or timeout
//   o_rsp_timeout       error was caused by the timeout
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   registered APB request signals
//   PREADY, PRDATA, PSLVERR                per-slave APB return signals
// -----------------------------------------------------------------------------
module apb_master_n
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned N_SLV   = 4,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned SEL_W  = clog2_min1(N_SLV)
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_write,
  input  logic [SEL_W-1:0]        i_req_sel,
  input  logic [ADDR_W-1:0]       i_req_addr,
  input  logic [DATA_W-1:0]       i_req_wdata,
  output logic                    o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic                    o_rsp_timeout,
  output logic [N_SLV-1:0]        PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_W-1:0]       PADDR,
  output logic [DATA_W-1:0]       PWDATA,
  input  logic [N_SLV-1:0]        PREADY,
  input  logic [N_SLV*DATA_W-1:0] PRDATA,
  input  logic [N_SLV-1:0]        PSLVERR
);

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W = clog2_min1(TIMEOUT);

  apb_state_e         state_q;
  logic [SEL_W-1:0]   sel_q;
  logic               write_q;
  logic [CNT_W-1:0]   to_cnt_q;

  logic               mux_ready_c;
  logic [DATA_W-1:0]  mux_rdata_c;
  logic               mux_err_c;
  logic               sel_ok_c;
  logic               to_hit_c;
  logic               cmpl_c;
  logic               free_c;
  logic               accept_c;
  logic               rsp_fire_c;
  logic [N_SLV-1:0]   onehot_c;
  rsp_err_e           cause_c;

  // Return path of the slave captured at accept time.
  apb_slave_mux #(
    .DATA_W (DATA_W),
    .N_SLV  (N_SLV),
    .SEL_W  (SEL_W)
  ) u_slave_mux (
    .sel     (sel_q),
    .pready  (PREADY),
    .prdata  (PRDATA),
    .pslverr (PSLVERR),
    .ready_c (mux_ready_c),
    .rdata_c (mux_rdata_c),
    .err_c   (mux_err_c)
  );

  // Handshake and completion decode.
  assign sel_ok_c = (32'(i_req_sel) < N_SLV);
  assign to_hit_c = (TIMEOUT != 0) && (to_cnt_q == CNT_W'(TIMEOUT - 1));
  assign cmpl_c   = (state_q == ACCESS) && (mux_ready_c || to_hit_c);
  assign free_c   = (state_q == IDLE) || cmpl_c;

  // A decode error on a completion cycle would need a second response pulse
  // in the same cycle, so such a request waits for IDLE one cycle later.
  assign o_req_ready = (state_q == IDLE) || (cmpl_c && sel_ok_c);
  assign accept_c    = i_req_valid && o_req_ready;
  assign rsp_fire_c  = cmpl_c || (accept_c && !sel_ok_c);
  assign onehot_c    = N_SLV'(1) << i_req_sel;

  // Cause of the response produced this cycle (PREADY beats the timeout).
  always_comb begin
    cause_c = ERR_NONE;
    if (state_q == ACCESS) begin
      if (mux_ready_c) begin
        cause_c = mux_err_c ? ERR_SLAVE : ERR_NONE;
      end else if (to_hit_c) begin
        cause_c = ERR_TIMEOUT;
      end
    end else if (state_q == IDLE && !sel_ok_c) begin
      cause_c = ERR_DECODE;
    end
  end

  // Phase FSM with registered bus and response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      write_q       <= READ;
      to_cnt_q      <= '0;
      PSEL          <= '0;
      PENABLE       <= 1'b0;
      PWRITE        <= 1'b0;
      PADDR         <= '0;
      PWDATA        <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;

      if (rsp_fire_c) begin
        o_rsp_valid   <= 1'b1;
        o_rsp_err     <= (cause_c != ERR_NONE);
        o_rsp_timeout <= (cause_c == ERR_TIMEOUT);
        o_rsp_rdata   <= (cause_c == ERR_NONE && write_q == READ) ? mux_rdata_c : '0;
      end

      unique case (state_q)
        SETUP: begin
          state_q <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (!cmpl_c) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // Either launch the next transfer or park the bus.
      if (free_c) begin
        if (accept_c && sel_ok_c) begin
          state_q  <= SETUP;
          sel_q    <= i_req_sel;
          write_q  <= i_req_write;
          to_cnt_q <= '0;
          PSEL     <= onehot_c;
          PENABLE  <= 1'b0;
          PWRITE   <= i_req_write;
          PADDR    <= i_req_addr;
          PWDATA   <= (i_req_write == WRITE) ? i_req_wdata : '0;
        end else begin
          state_q  <= IDLE;
          PSEL     <= '0;
          PENABLE  <= 1'b0;
          PWRITE   <= 1'b0;
          PADDR    <= '0;
          PWDATA   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_n.sv
// -----------------------------------------------------------------------------
// tb_apb_master_n
// Directed bench for apb_master_n. Instance "a": 4 slaves, TIMEOUT=4.
// Instance "b": 3 slaves, timeout disabled (decode error and reset abort).
// -----------------------------------------------------------------------------
module tb_apb_master_n;

  logic PCLK;
  logic PRESET;

  // Instance a
  logic        req_valid_a, req_ready_a, req_write_a;
  logic [1:0]  req_sel_a;
  logic [7:0]  req_addr_a, req_wdata_a;
  logic        rsp_valid_a, rsp_err_a, rsp_to_a;
  logic [7:0]  rsp_rdata_a;
  logic [3:0]  psel_a;
  logic        penable_a, pwrite_a;
  logic [7:0]  paddr_a, pwdata_a;
  logic [3:0]  pready_a, pslverr_a;
  logic [31:0] prdata_a;

  // Instance b
  logic        req_valid_b, req_ready_b, req_write_b;
  logic [1:0]  req_sel_b;
  logic [7:0]  req_addr_b, req_wdata_b;
  logic        rsp_valid_b, rsp_err_b, rsp_to_b;
  logic [7:0]  rsp_rdata_b;
  logic [2:0]  psel_b;
  logic        penable_b, pwrite_b;
  logic [7:0]  paddr_b, pwdata_b;
  logic [2:0]  pready_b, pslverr_b;
  logic [23:0] prdata_b;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_n #(.DATA_W(8), .ADDR_W(8), .N_SLV(4), .TIMEOUT(4)) u_dut_a (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .i_req_valid   (req_valid_a),
    .o_req_ready   (req_ready_a),
    .i_req_write   (req_write_a),
    .i_req_sel     (req_sel_a),
    .i_req_addr    (req_addr_a),
    .i_req_wdata   (req_wdata_a),
    .o_rsp_valid   (rsp_valid_a),
    .o_rsp_rdata   (rsp_rdata_a),
    .o_rsp_err     (rsp_err_a),
    .o_rsp_timeout (rsp_to_a),
    .PSEL          (psel_a),
    .PENABLE       (penable_a),
    .PWRITE        (pwrite_a),
    .PADDR         (paddr_a),
    .PWDATA        (pwdata_a),
    .PREADY        (pready_a),
    .PRDATA        (prdata_a),
    .PSLVERR       (pslverr_a)
  );

  apb_master_n #(.DATA_W(8), .ADDR_W(8), .N_SLV(3), .TIMEOUT(0)) u_dut_b (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .i_req_valid   (req_valid_b),
    .o_req_ready   (req_ready_b),
    .i_req_write   (req_write_b),
    .i_req_sel     (req_sel_b),
    .i_req_addr    (req_addr_b),
    .i_req_wdata   (req_wdata_b),
    .o_rsp_valid   (rsp_valid_b),
    .o_rsp_rdata   (rsp_rdata_b),
    .o_rsp_err     (rsp_err_b),
    .o_rsp_timeout (rsp_to_b),
    .PSEL          (psel_b),
    .PENABLE       (penable_b),
    .PWRITE        (pwrite_b),
    .PADDR         (paddr_b),
    .PWDATA        (pwdata_b),
    .PREADY        (pready_b),
    .PRDATA        (prdata_b),
    .PSLVERR       (pslverr_b)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic req_a(input logic v, input logic w, input logic [1:0] s,
                       input logic [7:0] ad, input logic [7:0] wd);
    req_valid_a = v; req_write_a = w; req_sel_a = s;
    req_addr_a  = ad; req_wdata_a = wd;
  endtask

  initial begin
    PRESET = 1'b1;
    req_a(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    pready_a  = 4'hF;
    pslverr_a = 4'h0;
    prdata_a  = {8'hFF, 8'h33, 8'h5A, 8'h11};
    req_valid_b = 1'b0; req_write_b = 1'b0; req_sel_b = 2'd0;
    req_addr_b  = 8'h00; req_wdata_b = 8'h00;
    pready_b  = 3'b000;
    pslverr_b = 3'b000;
    prdata_b  = {8'hC3, 8'hB2, 8'hA1};

    // Reset state
    tick(); tick();
    chk("rst_psel_a",    32'(psel_a), 32'h0);
    chk("rst_penable_a", 32'(penable_a), 32'h0);
    chk("rst_paddr_a",   32'(paddr_a), 32'h0);
    chk("rst_pwdata_a",  32'(pwdata_a), 32'h0);
    chk("rst_rsp_a",     32'({rsp_valid_a, rsp_err_a, rsp_to_a}), 32'h0);
    chk("rst_psel_b",    32'(psel_b), 32'h0);
    PRESET = 1'b0;
    #1 chk("rst_ready_a", 32'(req_ready_a), 32'h1);

    // Zero-wait write to slave 2
    req_a(1'b1, 1'b1, 2'd2, 8'h3C, 8'hA5);
    tick();
    req_valid_a = 1'b0;
    chk("t1_setup_psel",    32'(psel_a), 32'h4);
    chk("t1_setup_penable", 32'(penable_a), 32'h0);
    chk("t1_setup_paddr",   32'(paddr_a), 32'h3C);
    chk("t1_setup_pwrite",  32'(pwrite_a), 32'h1);
    chk("t1_setup_pwdata",  32'(pwdata_a), 32'hA5);
    #1 chk("t1_setup_ready", 32'(req_ready_a), 32'h0);
    tick();
    chk("t1_acc_psel",    32'(psel_a), 32'h4);
    chk("t1_acc_penable", 32'(penable_a), 32'h1);
    chk("t1_acc_pwdata",  32'(pwdata_a), 32'hA5);
    chk("t1_acc_rspv",    32'(rsp_valid_a), 32'h0);
    tick();
    chk("t1_rsp",      32'({rsp_valid_a, rsp_err_a, rsp_to_a}), 32'h4);
    chk("t1_rsp_data", 32'(rsp_rdata_a), 32'h0);
    chk("t1_idle_bus", 32'({psel_a, penable_a, paddr_a}), 32'h0);
    tick();
    chk("t1_pulse", 32'(rsp_valid_a), 32'h0);

    // Read from slave 1 with three wait states; the last ACCESS cycle is
    // also the timeout cycle, so PREADY must win.
    pready_a = 4'h0;
    req_a(1'b1, 1'b0, 2'd1, 8'h11, 8'h77);
    tick();
    req_valid_a = 1'b0;
    chk("t2_setup_psel",   32'(psel_a), 32'h2);
    chk("t2_setup_pwdata", 32'(pwdata_a), 32'h0);
    chk("t2_setup_pwrite", 32'(pwrite_a), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) pready_a = 4'h2;
      chk($sformatf("t2_acc%0d_penable", i), 32'(penable_a), 32'h1);
      chk($sformatf("t2_acc%0d_rspv", i), 32'(rsp_valid_a), 32'h0);
      #1 chk($sformatf("t2_acc%0d_ready", i), 32'(req_ready_a), (i == 4) ? 32'h1 : 32'h0);
    end
    tick();
    pready_a = 4'h0;
    chk("t2_rsp",      32'({rsp_valid_a, rsp_err_a, rsp_to_a}), 32'h4);
    chk("t2_rsp_data", 32'(rsp_rdata_a), 32'h5A);

    // Read from slave 3 answering with PSLVERR
    pready_a  = 4'h8;
    pslverr_a = 4'h8;
    req_a(1'b1, 1'b0, 2'd3, 8'h80, 8'h00);
    tick();
    req_valid_a = 1'b0;
    chk("t3_setup_psel", 32'(psel_a), 32'h8);
    tick();
    tick();
    chk("t3_rsp",      32'({rsp_valid_a, rsp_err_a, rsp_to_a}), 32'h6);
    chk("t3_rsp_data", 32'(rsp_rdata_a), 32'h0);
    pslverr_a = 4'h0;

    // Timeout: slave 0 never ready while the others are
    pready_a = 4'hE;
    req_a(1'b1, 1'b0, 2'd0, 8'h44, 8'h00);
    tick();
    req_valid_a = 1'b0;
    chk("t4_setup_psel", 32'(psel_a), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t4_acc%0d_bus", i), 32'({psel_a, penable_a}), 32'h3);
      chk($sformatf("t4_acc%0d_rspv", i), 32'(rsp_valid_a), 32'h0);
    end
    tick();
    chk("t4_rsp",      32'({rsp_valid_a, rsp_err_a, rsp_to_a}), 32'h7);
    chk("t4_rsp_data", 32'(rsp_rdata_a), 32'h0);
    chk("t4_idle_bus", 32'({psel_a, penable_a}), 32'h0);
    #1 chk("t4_ready", 32'(req_ready_a), 32'h1);
    tick();

    // Back-to-back writes to slave 0 then slave 1
    pready_a = 4'hF;
    req_a(1'b1, 1'b1, 2'd0, 8'h10, 8'h01);
    tick();
    chk("t5_setup0", 32'({psel_a, penable_a}), 32'h2);
    req_a(1'b1, 1'b1, 2'd1, 8'h20, 8'h02);
    tick();
    chk("t5_acc0", 32'({psel_a, penable_a}), 32'h3);
    #1 chk("t5_acc0_ready", 32'(req_ready_a), 32'h1);
    tick();
    req_valid_a = 1'b0;
    chk("t5_setup1",        32'({psel_a, penable_a}), 32'h4);
    chk("t5_setup1_paddr",  32'(paddr_a), 32'h20);
    chk("t5_setup1_pwdata", 32'(pwdata_a), 32'h02);
    chk("t5_rsp0",          32'({rsp_valid_a, rsp_err_a}), 32'h2);
    tick();
    chk("t5_acc1",  32'({psel_a, penable_a}), 32'h5);
    chk("t5_gap",   32'(rsp_valid_a), 32'h0);
    tick();
    chk("t5_rsp1",  32'({rsp_valid_a, rsp_err_a}), 32'h2);
    chk("t5_idle",  32'(psel_a), 32'h0);

    // Decode error on the 3-slave instance
    req_valid_b = 1'b1; req_write_b = 1'b1; req_sel_b = 2'd3;
    req_addr_b  = 8'h55; req_wdata_b = 8'h66;
    #1 chk("t6_ready", 32'(req_ready_b), 32'h1);
    tick();
    req_valid_b = 1'b0;
    chk("t6_rsp",  32'({rsp_valid_b, rsp_err_b, rsp_to_b}), 32'h6);
    chk("t6_data", 32'(rsp_rdata_b), 32'h0);
    chk("t6_bus",  32'({psel_b, penable_b}), 32'h0);
    tick();
    chk("t6_pulse", 32'(rsp_valid_b), 32'h0);

    // Stalled read with timeout disabled, then reset mid-ACCESS
    req_valid_b = 1'b1; req_write_b = 1'b0; req_sel_b = 2'd2;
    req_addr_b  = 8'h9A;
    tick();
    req_valid_b = 1'b0;
    chk("t7_setup_psel", 32'(psel_b), 32'h4);
    for (int i = 0; i < 20; i++) tick();
    chk("t7_stall_bus",  32'({psel_b, penable_b}), 32'h9);
    chk("t7_stall_rspv", 32'(rsp_valid_b), 32'h0);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("t7_rst_bus",  32'({psel_b, penable_b, pwrite_b}), 32'h0);
    chk("t7_rst_addr", 32'(paddr_b), 32'h0);
    chk("t7_rst_rspv", 32'(rsp_valid_b), 32'h0);
    tick();
    chk("t7_after_rspv", 32'(rsp_valid_b), 32'h0);
    chk("t7_after_bus",  32'({psel_b, penable_b}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master_n.md
Name: apb_master_n

Overview:
- Parametrised APB master for the protocol-select datapath: a single-transfer requester on one side, an APB bus with N_SLV slave selects on the other.
- Generalises the fixed 4-slave, write-centric controller: configurable data/address width and slave count, addressed reads and writes, PSLVERR capture, ACCESS-phase timeout, back-to-back transfers without returning to IDLE.
- Sits between the ALU/control block and the peripheral slaves.

Parameters:
- DATA_W, 8, PWDATA/PRDATA width.
- ADDR_W, 8, PADDR width.
- N_SLV, 4, number of slaves / PSEL lines (>=1).
- TIMEOUT, 16, max ACCESS cycles before abort; 0 disables timeout.
- SEL_W, $clog2(N_SLV) (min 1), select index width (localparam).

Ports:
- PCLK  in  1  clock; all state changes on posedge.
- PRESET  in  1  synchronous active-high reset.
- i_req_valid  in  1  transfer request.
- o_req_ready  out  1  request accepted when i_req_valid & o_req_ready at posedge.
- i_req_write  in  1  1=write, 0=read.
- i_req_sel  in  SEL_W  target slave index.
- i_req_addr  in  ADDR_W  transfer address.
- i_req_wdata  in  DATA_W  write data.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- o_rsp_err  out  1  PSLVERR, decode error or timeout.
- o_rsp_timeout  out  1  error cause was timeout.
- PSEL  out  N_SLV  one-hot slave select.
- PENABLE, PWRITE  out  1 each.
- PADDR  out  ADDR_W.
- PWDATA  out  DATA_W.
- PREADY  in  N_SLV  per-slave ready.
- PRDATA  in  N_SLV*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W].
- PSLVERR  in  N_SLV  per-slave error.

Behaviour:
- Reset (PRESET=1 at posedge): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, o_rsp_*=0, timeout counter=0.
- Reset mid-transfer aborts it silently: no response pulse, bus idle on the next cycle.
- States (enum in package):
  - IDLE: bus outputs all 0.
  - SETUP: PSEL[sel]=1, PENABLE=0.
  - ACCESS: PSEL[sel]=1, PENABLE=1.
- All APB outputs and o_rsp_* are registered; o_req_ready is combinational.
- o_req_ready=1 in IDLE, or in ACCESS on the completion cycle; 0 in SETUP.
- Completion cycle = selected PREADY=1 or timeout reached.
- Accept: capture write/sel/addr/wdata.
  - sel<N_SLV: next state SETUP.
  - sel>=N_SLV: no bus cycle; next cycle o_rsp_valid=1, o_rsp_err=1; state IDLE.
- SETUP always moves to ACCESS after 1 cycle. PADDR/PWRITE/PWDATA are stable from SETUP through the final ACCESS cycle. PWDATA=0 for reads.
- ACCESS: the selected slave's PREADY/PRDATA/PSLVERR are muxed by the captured sel.
  - PREADY=1: the next cycle carries o_rsp_valid=1, o_rsp_err=PSLVERR[sel], o_rsp_rdata=(read & ~PSLVERR)?PRDATA:0.
  - PREADY=0: stay in ACCESS, counter+1.
- Zero-wait latency: accept at edge k; SETUP after k, ACCESS after k+1, o_rsp_valid high after k+2.
- Timeout: the counter counts ACCESS cycles with PREADY=0. At count==TIMEOUT-1 with PREADY still 0, the next cycle has o_rsp_valid=1, o_rsp_err=1, o_rsp_timeout=1, and PSEL/PENABLE drop. Counter clears on entering SETUP.
- Back-to-back: request accepted on a completion cycle goes directly to SETUP; PSEL stays asserted if the slave is the same, otherwise switches one-hot. PENABLE drops for exactly 1 cycle.
- Simultaneous PREADY and timeout in the same cycle: PREADY wins, normal completion.
- The response is a pulse with no backpressure; requester must sample it.
- Inputs on other PREADY/PSLVERR bits are ignored.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS};
  - READ/WRITE constants;
  - response-error cause constants.
- Sub-module apb_slave_mux:
  - combinational selection of PREADY/PRDATA/PSLVERR by sel;
  - returns ready=0 and err=1 for out-of-range sel.

Test Plan:
- Zero-wait write, sel=2, addr=0x3C, wdata=0xA5, slave PREADY always 1.
  - Response: PSEL=4'b0100 for 2 cycles, PENABLE only in 2nd.
  - o_rsp_valid 3 cycles after accept, err=0.
- Read, sel=1, slave holds PREADY=0 for 3 ACCESS cycles then returns PRDATA=0x5A.
  - Response: 4 ACCESS cycles, o_rsp_rdata=0x5A, err=0.
- Read, sel=3, PREADY=1 with PSLVERR=1, PRDATA=0xFF.
  - Response: o_rsp_err=1, o_rsp_rdata=0, o_rsp_timeout=0.
- TIMEOUT=4, slave never ready.
  - Response: exactly 4 ACCESS cycles, then o_rsp_err=1 and o_rsp_timeout=1, bus idle, o_req_ready=1.
- Back-to-back: writes to sel 0 then sel 1 with i_req_valid held.
  - Response: no IDLE cycle; PSEL goes 0001 → 0010 with a single PENABLE=0 SETUP cycle between.
- N_SLV=3, sel=3; separately, PRESET=1 asserted mid-ACCESS.
  - sel=3: immediate decode error, no PSEL.
  - Reset mid-ACCESS: all outputs 0 next cycle, no response pulse.
